// File: rtl/keypad_bcd_entry_pkg.sv
// keypad_pkg: shared FSM states, code constants and one-hot helpers for the keypad entry block
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_NONE = 4'b1111;
  function automatic logic is_onehot(input logic [15:0] v);
    return v != 16'd0 && (v & (v - 16'd1)) == 16'd0;
  endfunction
  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [15:0] v);
    logic [CODE_W-1:0] r;
    r = CODE_NONE;
    for (int i = 0; i < 16; i++) if (v == (16'd1 << i)) r = CODE_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/keypad_bcd_entry_if.sv
// keypad_bcd_entry_if: keypad inputs plus encoded code and entry-buffer outputs
interface keypad_bcd_entry_if #(parameter int N_KEYS = 10, parameter int N_DIGITS = 4);
  localparam int CW = $clog2(N_DIGITS + 1);
  logic enablen;
  logic [N_KEYS-1:0] keypad;
  logic clear;
  logic [3:0] code;
  logic code_valid;
  logic key_error;
  logic overflow;
  logic [4*N_DIGITS-1:0] digits;
  logic [CW-1:0] count;
  logic full;
  modport master(output enablen, keypad, clear, input code, code_valid, key_error, overflow, digits, count, full);
  modport slave(input enablen, keypad, clear, output code, code_valid, key_error, overflow, digits, count, full);
endinterface

// File: rtl/keypad_bcd_entry_debouncer.sv
// key_debouncer: registers the keypad and debounces press/release, pulsing accept once per press
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int N_KEYS = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enablen,
  input  logic [N_KEYS-1:0] keypad,
  output logic              accept_pulse,
  output logic [N_KEYS-1:0] cand
);
  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [N_KEYS-1:0] keypad_q, cand_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      keypad_q <= '0;
      cand_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      keypad_q <= keypad;
      cand_q <= cand;
    end
  end
  // cand follows keypad_q while pressing, so the accepted pattern is always the current one
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand = cand_q;
    accept_pulse = 1'b0;
    if (enablen) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE || state == PRESS_DB) begin
      if (keypad_q == '0) begin
        state_n = IDLE;
      end else begin
        cand = keypad_q;
        cnt_n = (state == PRESS_DB && keypad_q == cand_q) ? cnt + 8'd1 : 8'd1;
        accept_pulse = cnt_n >= DB;
        state_n = accept_pulse ? HELD : PRESS_DB;
      end
    end else if (keypad_q != '0) begin
      state_n = HELD;
    end else begin
      cnt_n = state == RELEASE_DB ? cnt + 8'd1 : 8'd1;
      state_n = cnt_n >= DB ? IDLE : RELEASE_DB;
    end
  end
endmodule

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry: debounced one-hot keypad encoder feeding a shift-in digit entry buffer
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int N_KEYS = 10,
  parameter int N_DIGITS = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  keypad_bcd_entry_if.slave bus
);
  localparam int DW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  logic accept, onehot, push;
  logic [N_KEYS-1:0] cand;
  logic [CODE_W-1:0] cand_code;
  key_debouncer #(.N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .reset(reset),
    .enablen(bus.enablen),
    .keypad(bus.keypad),
    .accept_pulse(accept),
    .cand(cand)
  );
  assign onehot = is_onehot(16'(cand));
  assign cand_code = onehot_to_code(16'(cand));
  assign push = accept && onehot;
  assign bus.full = bus.count == CW'(N_DIGITS);
  // clear wins over a same-cycle push; the digit is dropped but still reported on code
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.code <= CODE_NONE;
      bus.code_valid <= 1'b0;
      bus.key_error <= 1'b0;
      bus.overflow <= 1'b0;
      bus.digits <= '0;
      bus.count <= '0;
    end else begin
      bus.code_valid <= push;
      bus.key_error <= accept && !onehot;
      bus.overflow <= push && bus.full && !bus.clear;
      if (push) bus.code <= cand_code;
      if (bus.clear) begin
        bus.digits <= '0;
        bus.count <= '0;
      end else if (push && !bus.full) begin
        bus.digits <= DW'({bus.digits, cand_code});
        bus.count <= bus.count + CW'(1);
      end
    end
  end
endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
Parametrised successor to the single-shot keypad encoder. It debounces a one-hot keypad and encodes each accepted key to a 4-bit code (digits 0-9, and hex A-F when N_KEYS>10). Each accepted key emits one valid pulse per press, and accepted digits accumulate into an N_DIGITS-deep BCD entry register. The block sits between the raw keypad inputs and the input-control logic that consumes multi-digit values.

Parameters:
N_KEYS, 10, number of key lines; legal range 2..16; key i encodes to 4'(i)
N_DIGITS, 4, depth of the digit entry buffer; legal range 1..8
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
enablen  in  1  active-low enable; when high, the scanner is held idle
keypad  in  N_KEYS  raw key lines, one-hot when a single key is pressed
clear  in  1  synchronous clear of the entry buffer
code  out  4  code of the last accepted key; 4'b1111 when none
code_valid  out  1  one-cycle pulse per accepted single-key press
key_error  out  1  one-cycle pulse when a debounced multi-hot pattern is accepted
overflow  out  1  one-cycle pulse when a digit is accepted while the buffer is full
digits  out  4*N_DIGITS  entry buffer; newest digit in [3:0]
count  out  $clog2(N_DIGITS+1)  number of digits held
full  out  1  high when count==N_DIGITS

Behaviour:
- Clock, reset and synchronicity are fixed: one clock (clk); reset is synchronous and active-high.
- Reset values: code=4'b1111, code_valid=0, key_error=0, overflow=0, digits=0, count=0, full=0, FSM=IDLE, debounce counter=0, keypad_q=0.
- Input stage: keypad is registered once into keypad_q. All decisions use keypad_q.
- FSM states:
  - IDLE: if keypad_q!=0, latch cand=keypad_q, cnt=1, go to PRESS_DB.
  - PRESS_DB:
    - If keypad_q==0, go to IDLE.
    - If keypad_q!=cand, set cand=keypad_q, cnt=1, and stay.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, accept the press and go to HELD.
  - HELD: if keypad_q==0, set cnt=1 and go to RELEASE_DB. A different nonzero pattern is ignored (no auto-repeat, no rollover).
  - RELEASE_DB:
    - If keypad_q!=0, go to HELD.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Accept:
  - cand one-hot: code=index of cand, code_valid pulses for 1 cycle; the digit is pushed.
  - cand multi-hot: key_error pulses; code and the buffer are unchanged.
- Latency: a stable key applied before edge k is sampled into keypad_q at edge k. code_valid is high in the cycle following edge k+DEBOUNCE_CYCLES.
- Push:
  - If !full: digits = {digits[4*N_DIGITS-5:0], code}, count++.
  - If full: overflow pulses, digits and count are unchanged; code and code_valid still update.
- clear (when reset is low): digits=0, count=0. clear has priority over a push in the same cycle; that digit is discarded from the buffer, but code_valid still pulses.
- enablen=1: FSM forced to IDLE and cnt=0; pulses are suppressed. code, digits and count hold; clear still works. Deasserting enablen restarts debouncing from IDLE, so a key held across enable produces exactly one code_valid.
- reset mid-debounce or mid-press: state returns to reset values. A key still held afterwards is re-debounced and accepted once.
- code_valid, key_error and overflow are mutually exclusive except code_valid with overflow, which may pulse together.
- Digit values follow the key index. With N_KEYS<=10 the buffer is pure BCD.

Decomposition:
- Shared package (keypad_pkg):
  - state enum {IDLE, PRESS_DB, HELD, RELEASE_DB}
  - CODE_NONE=4'b1111
  - CODE_W=4
  - function onehot_to_code (returns the index, or CODE_NONE for a non-one-hot pattern)
  - function is_onehot
- Sub-module key_debouncer: input register plus FSM plus counter. Outputs accept_pulse and cand. The top level handles encoding and the entry buffer.

Test Plan:
- Defaults; hold keypad=10'b0000001000 for 10 cycles -> exactly one code_valid, code=4'd3 in the cycle after edge k+4, digits[3:0]=3, count=1.
- Bounce: keypad toggles 0x008/0x000 every 2 cycles for 8 cycles, then stable 0x008 -> no accept during the bounce; one code_valid after 4 stable cycles.
- Enter 1,2,3,4,5 (N_DIGITS=4) -> digits=16'h1234, full=1, then overflow=1 with code=5 and code_valid=1 on the fifth press; digits unchanged.
- keypad=10'b0000000101 stable -> key_error pulse, code stays at its previous value, count unchanged.
- clear asserted in the same cycle as the accept of key 7 with count=2 -> count=0, digits=0, code_valid=1, code=7.
- Key held while reset pulses mid-HELD, then held 6 more cycles -> outputs at reset values, then exactly one new code_valid. Repeat with enablen toggled high for 3 cycles instead of reset -> the same single re-accept.
